// File: rtl/lif_net_param.sv
// Two-layer leaky integrate-and-fire network: N_IN input neurons feed a signed,
// runtime-loadable weight file whose summed output drives a single output neuron.
module lif_net_param #(
    parameter int N_IN       = 8,
    parameter int W          = 8,
    parameter int THRESH     = 200,
    parameter int THRESH_OUT = 4,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int WGT_W      = 4,
    parameter int WGT_RESET  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [N_IN*W-1:0]         current,
    input  logic                      cfg_we,
    input  logic [$clog2(N_IN)-1:0]   cfg_addr,
    input  logic signed [WGT_W-1:0]   cfg_data,
    input  logic                      cnt_clr,
    output logic [N_IN-1:0]           hid_spike,
    output logic                      spike_out,
    output logic [W-1:0]              state_out,
    output logic [15:0]               spike_cnt
);

    localparam int SW = $clog2(N_IN) + WGT_W + 1;
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [W:0] SAT = {1'b0, {W{1'b1}}};

    typedef struct packed {
        logic [W-1:0]  state;
        logic [RW-1:0] ref_cnt;
        logic          spike;
    } neuron_t;

    // Shared neuron update: refractory hold, else leak + integrate with saturation.
    function automatic neuron_t neuron_step(input neuron_t cur, input logic [W-1:0] din,
                                            input int thresh);
        neuron_t    nxt;
        logic [W:0] n;
        nxt = cur;
        n   = '0;
        if (cur.ref_cnt != '0) begin
            nxt.state   = '0;
            nxt.spike   = 1'b0;
            nxt.ref_cnt = cur.ref_cnt - RW'(1);
        end else begin
            n = {1'b0, cur.state} - {1'b0, (cur.state >> LEAK_SHIFT)} + {1'b0, din};
            if (n > SAT) n = SAT;
            if (int'(n) >= thresh) begin
                nxt.spike   = 1'b1;
                nxt.state   = '0;
                nxt.ref_cnt = RW'(REFRAC);
            end else begin
                nxt.spike   = 1'b0;
                nxt.state   = n[W-1:0];
            end
        end
        return nxt;
    endfunction

    logic [W-1:0]              hid_state [N_IN];
    logic [RW-1:0]             hid_ref   [N_IN];
    logic signed [WGT_W-1:0]   wgt       [N_IN];
    logic signed [SW-1:0]      sum;
    logic [RW-1:0]             out_ref;

    neuron_t                   hid_nxt [N_IN];
    neuron_t                   out_nxt;
    logic signed [SW-1:0]      sum_nxt;
    logic [W-1:0]              out_in;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sum_nxt = '0;
        for (int i = 0; i < N_IN; i++) begin
            hid_nxt[i] = neuron_step('{state: hid_state[i], ref_cnt: hid_ref[i], spike: hid_spike[i]},
                                     current[i*W +: W], THRESH);
            if (hid_spike[i])
                sum_nxt = sum_nxt + {{(SW-WGT_W){wgt[i][WGT_W-1]}}, wgt[i]};
        end
    end

    // Negative sums inhibit down to zero drive; large sums saturate the input.
    always_comb begin
        out_in = '0;
        if (sum[SW-1])
            out_in = '0;
        else if (longint'(sum) > ((longint'(1) << W) - 1))
            out_in = '1;
        else
            out_in = W'(sum);
        out_nxt = neuron_step('{state: state_out, ref_cnt: out_ref, spike: spike_out},
                              out_in, THRESH_OUT);
    end

    // NOTE: all state, including the weight file, is updated with non-blocking assignments
    // so every register samples pre-edge values; the weight file is reset because its
    // power-on value (WGT_RESET) is architecturally visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                hid_state[i] <= '0;
                hid_ref[i]   <= '0;
                wgt[i]       <= WGT_W'(WGT_RESET);
            end
            hid_spike <= '0;
            sum       <= '0;
            state_out <= '0;
            out_ref   <= '0;
            spike_out <= 1'b0;
            spike_cnt <= '0;
        end else begin
            if (cfg_we && (int'(cfg_addr) < N_IN))
                wgt[cfg_addr] <= cfg_data;

            if (ena) begin
                for (int i = 0; i < N_IN; i++) begin
                    hid_state[i] <= hid_nxt[i].state;
                    hid_ref[i]   <= hid_nxt[i].ref_cnt;
                    hid_spike[i] <= hid_nxt[i].spike;
                end
                sum       <= sum_nxt;
                state_out <= out_nxt.state;
                out_ref   <= out_nxt.ref_cnt;
                spike_out <= out_nxt.spike;
            end else begin
                hid_spike <= '0;
                spike_out <= 1'b0;
            end

            if (cnt_clr)
                spike_cnt <= '0;
            else if (ena && out_nxt.spike && (spike_cnt != 16'hFFFF))
                spike_cnt <= spike_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lif_net_param.sv
// Scoreboard bench for lif_net_param: stimulus pushes hand-computed expectations,
// a monitor pops one entry per edge and compares against the selected DUT instance.
`timescale 1ns/1ps
module tb_lif_net_param;

    localparam int N_IN = 8;
    localparam int W    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic                   ena;
    logic [N_IN*W-1:0]      current;
    logic                   cfg_we;
    logic [2:0]             cfg_addr;
    logic signed [3:0]      cfg_data;
    logic                   cnt_clr;
    logic [N_IN-1:0]        hid_spike;
    logic                   spike_out;
    logic [W-1:0]           state_out;
    logic [15:0]            spike_cnt;

    logic                   f_ena;
    logic                   f_cnt_clr;
    logic [N_IN-1:0]        f_hid;
    logic                   f_so;
    logic [W-1:0]           f_st;
    logic [15:0]            f_cnt;

    lif_net_param u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .current(current),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cnt_clr(cnt_clr),
        .hid_spike(hid_spike), .spike_out(spike_out), .state_out(state_out),
        .spike_cnt(spike_cnt)
    );

    // Refractory-free instance: fires every cycle, so the counter can reach saturation.
    lif_net_param #(.REFRAC(0)) u_fast (
        .clk(clk), .rst_n(rst_n), .ena(f_ena), .current({N_IN*W{1'b1}}),
        .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_data(4'sd0), .cnt_clr(f_cnt_clr),
        .hid_spike(f_hid), .spike_out(f_so), .state_out(f_st), .spike_cnt(f_cnt)
    );

    typedef struct {
        bit          sel;
        logic [7:0]  hid;
        logic        so;
        logic [7:0]  st;
        logic [15:0] cnt;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check({e.nm, ".hid"}, e.sel ? 32'(f_hid) : 32'(hid_spike), 32'(e.hid));
                check({e.nm, ".spike_out"}, e.sel ? 32'(f_so) : 32'(spike_out), 32'(e.so));
                check({e.nm, ".state_out"}, e.sel ? 32'(f_st) : 32'(state_out), 32'(e.st));
                check({e.nm, ".spike_cnt"}, e.sel ? 32'(f_cnt) : 32'(spike_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge with inputs already set; queues the result of the next edge.
    task automatic step(input string nm, input bit sel, input logic [7:0] hid, input logic so,
                        input logic [7:0] st, input logic [15:0] cnt);
        exp_t e;
        e.sel = sel; e.hid = hid; e.so = so; e.st = st; e.cnt = cnt; e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int st_integ [10] = '{0, 0, 0, 1, 1, 1, 1, 2, 1, 1};

    initial begin
        rst_n = 1'b0; ena = 1'b0; current = '0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_data = '0; cnt_clr = 1'b0; f_ena = 1'b0; f_cnt_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Integration and refractory on channel 0
        current = 64'd150;
        for (int e = 1; e <= 10; e++)
            step($sformatf("integ_e%0d", e), 1'b0,
                 (e == 2 || e == 6 || e == 10) ? 8'h01 : 8'h00, 1'b0, 8'(st_integ[e-1]), 16'd0);

        // Asynchronous reset mid-refractory
        rst_n = 1'b0;
        #1;
        check("rst_hid", 32'(hid_spike), 32'd0);
        check("rst_spike_out", 32'(spike_out), 32'd0);
        check("rst_state_out", 32'(state_out), 32'd0);
        check("rst_spike_cnt", 32'(spike_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_e1", 1'b0, 8'h00, 1'b0, 8'd0, 16'd0);
        step("post_rst_e2", 1'b0, 8'h01, 1'b0, 8'd0, 16'd0);

        // Saturation with default weights
        current = '1;
        reset_pulse();
        for (int e = 1; e <= 9; e++)
            step($sformatf("sat_e%0d", e), 1'b0,
                 (e % 3 == 1) ? 8'hFF : 8'h00, (e % 3 == 0), 8'd0, 16'(e / 3));

        // Inhibition, then re-excitation written on the same edge the sum uses weight[1]
        current = 64'h0000_0000_0000_FFFF;
        reset_pulse();
        for (int e = 1; e <= 13; e++) begin
            cfg_we   = (e == 1 || e == 8);
            cfg_addr = 3'd1;
            cfg_data = (e == 1) ? 4'sb1000 : 4'sd7;
            step($sformatf("inhib_e%0d", e), 1'b0,
                 (e % 3 == 1) ? 8'h03 : 8'h00, (e == 12), 8'd0, (e >= 12) ? 16'd1 : 16'd0);
            cfg_we = 1'b0;
        end

        // Enable freeze, weight write while frozen, counter clear while frozen
        current = 64'd150;
        reset_pulse();
        step("frz_e1", 1'b0, 8'h00, 1'b0, 8'd0, 16'd0);
        ena = 1'b0;
        for (int e = 2; e <= 6; e++) begin
            cfg_we   = (e == 3);
            cfg_addr = 3'd0;
            cfg_data = 4'sd5;
            step($sformatf("frz_e%0d", e), 1'b0, 8'h00, 1'b0, 8'd0, 16'd0);
            cfg_we = 1'b0;
        end
        ena = 1'b1;
        step("frz_e7", 1'b0, 8'h01, 1'b0, 8'd0, 16'd0);
        step("frz_e8", 1'b0, 8'h00, 1'b0, 8'd0, 16'd0);
        step("frz_e9", 1'b0, 8'h00, 1'b1, 8'd0, 16'd1);
        ena = 1'b0;
        cnt_clr = 1'b1;
        step("frz_clr_e10", 1'b0, 8'h00, 1'b0, 8'd0, 16'd0);
        cnt_clr = 1'b0;

        // Counter saturation and clear-with-spike on the refractory-free instance
        f_ena = 1'b1;
        for (int e = 1; e <= 65542; e++) begin
            f_cnt_clr = (e == 65541);
            if (e == 3)
                step("cnt_first", 1'b1, 8'hFF, 1'b1, 8'd0, 16'd1);
            else if (e == 65536)
                step("cnt_fffe", 1'b1, 8'hFF, 1'b1, 8'd0, 16'hFFFE);
            else if (e == 65537)
                step("cnt_sat", 1'b1, 8'hFF, 1'b1, 8'd0, 16'hFFFF);
            else if (e == 65540)
                step("cnt_hold", 1'b1, 8'hFF, 1'b1, 8'd0, 16'hFFFF);
            else if (e == 65541)
                step("cnt_clr_spike", 1'b1, 8'hFF, 1'b1, 8'd0, 16'd0);
            else if (e == 65542)
                step("cnt_after_clr", 1'b1, 8'hFF, 1'b1, 8'd0, 16'd1);
            else
                idle();
        end
        f_cnt_clr = 1'b0;

        @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
